fft_stage_ctrl: RTL and testbench

Sequencer for one radix-2 delay-feedback FFT stage: shift-register delay line, butterfly, then twiddle multiply. Counts accepted input beats and decides when beats are written into the delay line and when they pair with delayed data in the butterfly. Delays butterfly-valid through the twiddle pipeline to produce the stage output valid and end-of-frame pulses. One instance per stage; stage 0 uses the defaults.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_stage_if.sv | 28 ++
 rtl/valid_delay_line.sv | 34 +++
 rtl/fft_stage_ctrl.sv | 93 +++++++++
 tb/tb_fft_stage_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the radix-2 delay-feedback FFT stage controller.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      BFLY = 2'd2
   } state_e;

   localparam int NPOINT_DEF = 512;
   localparam int PAR_DEF    = 16;

   function automatic int blk_f(input int stage_depth, input int par);
      return stage_depth / par;
   endfunction

   function automatic int frame_beats_f(input int npoint, input int par);
      return npoint / par;
   endfunction

   function automatic int cnt_w_f(input int npoint, input int par);
      return $clog2(npoint / par);
   endfunction

   // A single-beat block still needs a one-bit index port.
   function automatic int idx_w_f(input int stage_depth, input int par);
      return (stage_depth / par > 1) ? $clog2(stage_depth / par) : 1;
   endfunction

endpackage

// File: rtl/fft_stage_if.sv
// Beat handshake in, stage control and status out, for one FFT stage sequencer.
interface fft_stage_if #(
   parameter int IDX_W = 4
);
   logic             din_valid;
   logic             din_sof;
   logic             shift_wr_en;
   logic             bfly_valid;
   logic [IDX_W-1:0] bfly_idx;
   logic             bfly_first;
   logic             out_valid;
   logic             frame_done;
   logic             drop;
   logic             sync_err;
   logic             busy;

   modport slave (
      input  din_valid, din_sof,
      output shift_wr_en, bfly_valid, bfly_idx, bfly_first,
             out_valid, frame_done, drop, sync_err, busy
   );

   modport master (
      output din_valid, din_sof,
      input  shift_wr_en, bfly_valid, bfly_idx, bfly_first,
             out_valid, frame_done, drop, sync_err, busy
   );
endinterface

// File: rtl/valid_delay_line.sv
// Fixed-latency shift register carrying valid/flag bits alongside the twiddle pipeline.
module valid_delay_line #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             pending_o
);

   logic [WIDTH-1:0] sr_q [DEPTH];

   // NOTE: this array is a handful of flops, not a RAM, so clearing it on reset is cheap and
   // guarantees no stale valid escapes after an abandoned frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   // Bit 0 is the valid bit; any valid still in flight keeps the stage busy.
   always_comb begin
      pending_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) pending_o = pending_o | sr_q[i][0];
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Beat sequencer for one radix-2 DIF delay-feedback stage: fill/butterfly phasing and
// valid/end-of-frame timing through the twiddle pipeline.
module fft_stage_ctrl
   import fft_pkg::*;
#(
   parameter int NPOINT      = NPOINT_DEF,
   parameter int PAR         = PAR_DEF,
   parameter int STAGE_DEPTH = 256,
   parameter int OUT_LAT     = 4,
   localparam int BLK         = blk_f(STAGE_DEPTH, PAR),
   localparam int FRAME_BEATS = frame_beats_f(NPOINT, PAR),
   localparam int CNT_W       = cnt_w_f(NPOINT, PAR),
   localparam int IDX_W       = idx_w_f(STAGE_DEPTH, PAR)
) (
   input  logic        clk,
   input  logic        rstn,
   fft_stage_if.slave  io
);

   localparam int              PH_BIT    = $clog2(BLK);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, eff_cnt;
   logic             drop_q, drop_d;
   logic             serr_q, serr_d;
   logic             acc, resync, phase, bfly_v, last;
   logic [1:0]       dly_q;
   logic             pending;

   // Outputs are gated by rstn so they drop the instant reset asserts, even with din_valid high.
   // NOTE: every signal written here gets a default first so no path can infer a latch.
   always_comb begin
      acc     = rstn & io.din_valid & ((state_q != IDLE) | io.din_sof);
      resync  = rstn & io.din_valid & io.din_sof & (state_q != IDLE) & (cnt_q != '0);
      eff_cnt = resync ? '0 : cnt_q;
      phase   = eff_cnt[PH_BIT];
      bfly_v  = acc & phase;
      last    = bfly_v & (eff_cnt == LAST_BEAT);

      state_d = state_q;
      cnt_d   = cnt_q;
      if (acc) begin
         if (eff_cnt == LAST_BEAT) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d   = eff_cnt + 1'b1;
            state_d = cnt_d[PH_BIT] ? BFLY : FILL;
         end
      end

      drop_d = io.din_valid & (state_q == IDLE) & ~io.din_sof;
      serr_d = resync;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
         serr_q  <= serr_d;
      end
   end

   valid_delay_line #(
      .WIDTH (2),
      .DEPTH (OUT_LAT)
   ) u_dly (
      .clk       (clk),
      .rstn      (rstn),
      .d_i       ({last, bfly_v}),
      .q_o       (dly_q),
      .pending_o (pending)
   );

   assign io.shift_wr_en = acc;
   assign io.bfly_valid  = bfly_v;
   assign io.bfly_idx    = eff_cnt[IDX_W-1:0];
   assign io.bfly_first  = bfly_v & (eff_cnt[IDX_W-1:0] == '0);
   assign io.out_valid   = dly_q[0];
   assign io.frame_done  = dly_q[1];
   assign io.drop        = drop_q;
   assign io.sync_err    = serr_q;
   assign io.busy        = (state_q != IDLE) | pending;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl (defaults): reference beat model plus an out_valid scoreboard.
module tb_fft_stage_ctrl;

   typedef struct {
      int due;
      bit last;
   } sb_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   fft_stage_if #(.IDX_W(4)) io ();

   fft_stage_ctrl dut (
      .clk  (clk),
      .rstn (rstn),
      .io   (io)
   );

   int  n_vec  = 0;
   int  n_err  = 0;
   int  cyc    = 0;
   int  m_cnt  = 0;
   int  fd_seen = 0;
   bit  m_active = 1'b0;
   bit  exp_drop = 1'b0;
   bit  exp_serr = 1'b0;
   sb_t sb_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: drive beat after the edge, compare at the falling edge, then advance the model.
   task automatic step(input bit v, input bit s);
      bit  acc, rs, bv, last, exp_ov, exp_fd, exp_busy;
      int  idx_full;
      sb_t e;
      @(posedge clk);
      #1;
      io.din_valid = v;
      io.din_sof   = s;
      @(negedge clk);
      acc      = v && (m_active || s);
      rs       = v && s && m_active;
      idx_full = (v && s) ? 0 : m_cnt;
      bv       = acc && (idx_full >= 16);
      last     = bv && (idx_full == 31);
      exp_ov   = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      exp_fd   = exp_ov && sb_q[0].last;
      exp_busy = m_active || ((sb_q.size() > 0) && (sb_q[0].due <= cyc + 3));
      check("shift_wr_en", 32'(io.shift_wr_en), 32'(acc));
      check("bfly_valid",  32'(io.bfly_valid),  32'(bv));
      check("bfly_idx",    32'(io.bfly_idx),    32'(idx_full % 16));
      check("bfly_first",  32'(io.bfly_first),  32'(bv && idx_full == 16));
      check("out_valid",   32'(io.out_valid),   32'(exp_ov));
      check("frame_done",  32'(io.frame_done),  32'(exp_fd));
      check("drop",        32'(io.drop),        32'(exp_drop));
      check("sync_err",    32'(io.sync_err),    32'(exp_serr));
      check("busy",        32'(io.busy),        32'(exp_busy));
      if (io.frame_done === 1'b1) fd_seen++;
      if (exp_ov) void'(sb_q.pop_front());
      if (bv) begin
         e.due  = cyc + 4;
         e.last = last;
         sb_q.push_back(e);
      end
      exp_drop = v && !m_active && !s;
      exp_serr = rs;
      if (acc) begin
         if (idx_full == 31) begin
            m_active = 1'b0;
            m_cnt    = 0;
         end else begin
            m_active = 1'b1;
            m_cnt    = idx_full + 1;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic outputs_zero(input string tag);
      check({tag, "_wr"},   32'(io.shift_wr_en), 32'd0);
      check({tag, "_bv"},   32'(io.bfly_valid),  32'd0);
      check({tag, "_idx"},  32'(io.bfly_idx),    32'd0);
      check({tag, "_bf"},   32'(io.bfly_first),  32'd0);
      check({tag, "_ov"},   32'(io.out_valid),   32'd0);
      check({tag, "_fd"},   32'(io.frame_done),  32'd0);
      check({tag, "_drop"}, 32'(io.drop),        32'd0);
      check({tag, "_serr"}, 32'(io.sync_err),    32'd0);
      check({tag, "_busy"}, 32'(io.busy),        32'd0);
   endtask

   // Reset mid-cycle with a beat on the bus: outputs must clear without waiting for a clock.
   task automatic reset_pulse();
      @(posedge clk);
      #1;
      io.din_valid = 1'b1;
      io.din_sof   = 1'b0;
      #1;
      rstn = 1'b0;
      #1;
      outputs_zero("rst_async");
      @(negedge clk);
      outputs_zero("rst_hold");
      io.din_valid = 1'b0;
      #1;
      rstn = 1'b1;
      sb_q.delete();
      m_active = 1'b0;
      m_cnt    = 0;
      exp_drop = 1'b0;
      exp_serr = 1'b0;
      cyc++;
   endtask

   task automatic frame_continuous();
      step(1'b1, 1'b1);
      for (int i = 1; i < 32; i++) step(1'b1, 1'b0);
   endtask

   initial begin
      io.din_valid = 1'b0;
      io.din_sof   = 1'b0;
      #12;
      outputs_zero("reset");
      @(negedge clk);
      rstn = 1'b1;

      // 1: one continuous frame
      fd_seen = 0;
      frame_continuous();
      idle(8);
      check("s1_frames", 32'(fd_seen), 32'd1);
      check("s1_drain", 32'(sb_q.size()), 32'd0);

      // 2: valid alternating 1/0, sof on first beat
      fd_seen = 0;
      for (int i = 0; i < 32; i++) begin
         step(1'b1, i == 0);
         step(1'b0, 1'b0);
      end
      idle(8);
      check("s2_frames", 32'(fd_seen), 32'd1);
      check("s2_drain", 32'(sb_q.size()), 32'd0);

      // 3: two frames back-to-back
      fd_seen = 0;
      frame_continuous();
      frame_continuous();
      idle(8);
      check("s3_frames", 32'(fd_seen), 32'd2);
      check("s3_drain", 32'(sb_q.size()), 32'd0);

      // 4: valid without sof while idle
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      idle(3);

      // 5: resync by a second sof on beat 10
      fd_seen = 0;
      step(1'b1, 1'b1);
      for (int i = 1; i < 10; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      for (int i = 1; i < 32; i++) step(1'b1, 1'b0);
      idle(8);
      check("s5_frames", 32'(fd_seen), 32'd1);
      check("s5_drain", 32'(sb_q.size()), 32'd0);

      // 6: reset at beat 20, then a clean frame
      fd_seen = 0;
      step(1'b1, 1'b1);
      for (int i = 1; i < 20; i++) step(1'b1, 1'b0);
      reset_pulse();
      idle(6);
      check("s6_abort_frames", 32'(fd_seen), 32'd0);
      frame_continuous();
      idle(8);
      check("s6_frames", 32'(fd_seen), 32'd1);
      check("s6_drain", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
